// File: rtl/axi_decerr_split.sv
// -----------------------------------------------------------------------------
// axi_decerr_split
//
// Address-decoding splitter that sits directly in front of the bus-error slave.
// Every AXI burst from the single upstream master (S_AXI_*) is steered by its
// address:
//   - hit  ((ADDR & SLAVE_MASK) == SLAVE_ADDR) -> mapped slave   (M_AXI_*)
//   - miss                                      -> error slave    (E_AXI_*)
// Responses from whichever slave currently owns a direction are returned to
// the master. Because a direction only changes target when nothing is
// outstanding, responses can never interleave between the two slaves, so
// AXI ID ordering is preserved without any reorder storage.
//
// All payloads are combinational passthroughs (zero latency). The only
// registered state is, per direction, a target-select bit and an outstanding
// burst counter, plus a count of write bursts whose W data is still due.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESET     clock, synchronous active-high reset
//   S_AXI_AW*/W*/B*/AR*/R*        slave port facing the upstream master
//   M_AXI_AW*/W*/B*/AR*/R*        master port to the mapped slave
//   E_AXI_AW*/W*/B*/AR*/R*        master port to the error slave
//   While S_AXI_ARESET is high every VALID and READY output is held low.
// -----------------------------------------------------------------------------
module axi_decerr_split #(
  parameter int C_AXI_ID_WIDTH = 2,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 32,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] SLAVE_ADDR = 32'h0000_0000,
  parameter logic [C_AXI_ADDR_WIDTH-1:0] SLAVE_MASK = 32'hffff_0000,
  parameter int LGMAXBURST = 3
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  // upstream master: write address
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]       S_AXI_AWID,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  // upstream master: write data
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  // upstream master: write response
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  output logic [C_AXI_ID_WIDTH-1:0]       S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  // upstream master: read address
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]       S_AXI_ARID,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  // upstream master: read data
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_AXI_ID_WIDTH-1:0]       S_AXI_RID,
  output logic [C_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic                            S_AXI_RLAST,
  output logic [1:0]                      S_AXI_RRESP,
  // mapped slave
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_AXI_ID_WIDTH-1:0]       M_AXI_AWID,
  output logic [C_AXI_ADDR_WIDTH-1:0]     M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]     M_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]       M_AXI_BID,
  input  logic [1:0]                      M_AXI_BRESP,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  output logic [C_AXI_ID_WIDTH-1:0]       M_AXI_ARID,
  output logic [C_AXI_ADDR_WIDTH-1:0]     M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]       M_AXI_RID,
  input  logic [C_AXI_DATA_WIDTH-1:0]     M_AXI_RDATA,
  input  logic                            M_AXI_RLAST,
  input  logic [1:0]                      M_AXI_RRESP,
  // error slave
  output logic                            E_AXI_AWVALID,
  input  logic                            E_AXI_AWREADY,
  output logic [C_AXI_ID_WIDTH-1:0]       E_AXI_AWID,
  output logic [C_AXI_ADDR_WIDTH-1:0]     E_AXI_AWADDR,
  output logic [7:0]                      E_AXI_AWLEN,
  output logic                            E_AXI_WVALID,
  input  logic                            E_AXI_WREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]     E_AXI_WDATA,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   E_AXI_WSTRB,
  output logic                            E_AXI_WLAST,
  input  logic                            E_AXI_BVALID,
  output logic                            E_AXI_BREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]       E_AXI_BID,
  input  logic [1:0]                      E_AXI_BRESP,
  output logic                            E_AXI_ARVALID,
  input  logic                            E_AXI_ARREADY,
  output logic [C_AXI_ID_WIDTH-1:0]       E_AXI_ARID,
  output logic [C_AXI_ADDR_WIDTH-1:0]     E_AXI_ARADDR,
  output logic [7:0]                      E_AXI_ARLEN,
  input  logic                            E_AXI_RVALID,
  output logic                            E_AXI_RREADY,
  input  logic [C_AXI_ID_WIDTH-1:0]       E_AXI_RID,
  input  logic [C_AXI_DATA_WIDTH-1:0]     E_AXI_RDATA,
  input  logic                            E_AXI_RLAST,
  input  logic [1:0]                      E_AXI_RRESP
);

  localparam logic [LGMAXBURST-1:0] MAX_OUT = {LGMAXBURST{1'b1}};

  // Per-direction views of the address channels: index 0 = write, 1 = read.
  logic [1:0]                       a_valid;
  logic [1:0][C_AXI_ADDR_WIDTH-1:0] a_addr;
  logic [1:0]                       m_aready;
  logic [1:0]                       e_aready;
  logic [1:0]                       rsp_done;   // burst completed on the response side
  logic [1:0]                       m_avalid;
  logic [1:0]                       e_avalid;
  logic [1:0]                       s_aready;
  logic [1:0]                       dir_sel;    // 0 = mapped slave, 1 = error slave

  assign a_valid  = {S_AXI_ARVALID, S_AXI_AWVALID};
  assign a_addr   = {S_AXI_ARADDR, S_AXI_AWADDR};
  assign m_aready = {M_AXI_ARREADY, M_AXI_AWREADY};
  assign e_aready = {E_AXI_ARREADY, E_AXI_AWREADY};
  assign rsp_done = {S_AXI_RVALID && S_AXI_RREADY && S_AXI_RLAST,
                     S_AXI_BVALID && S_AXI_BREADY};

  // Admission, routing and bookkeeping are identical for AW and AR.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dir
      logic [LGMAXBURST-1:0] out_reg, out_next;
      logic                  sel_reg, sel_next;
      logic                  hit;
      logic                  allowed;
      logic                  a_hs;

      assign hit = ((a_addr[gi] & SLAVE_MASK) == SLAVE_ADDR);

      // A burst may go out if nothing is in flight, or if it targets the
      // slave already owning this direction; never beyond MAX_OUT in flight.
      assign allowed = !S_AXI_ARESET
                       && ((out_reg == '0) || (hit == !sel_reg))
                       && (out_reg != MAX_OUT);

      assign m_avalid[gi] = a_valid[gi] && hit && allowed;
      assign e_avalid[gi] = a_valid[gi] && !hit && allowed;
      assign s_aready[gi] = allowed && (hit ? m_aready[gi] : e_aready[gi]);
      assign a_hs         = a_valid[gi] && s_aready[gi];
      assign dir_sel[gi]  = sel_reg;

      always_comb begin
        out_next = out_reg;
        sel_next = sel_reg;
        if (a_hs && !rsp_done[gi]) begin
          out_next = out_reg + 1'b1;
        end else if (!a_hs && rsp_done[gi]) begin
          out_next = out_reg - 1'b1;
        end
        // Only reachable with the same target or nothing outstanding, so
        // rewriting the select here never redirects an in-flight burst.
        if (a_hs) begin
          sel_next = !hit;
        end
      end

      always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
          out_reg <= '0;
          sel_reg <= 1'b0;
        end else begin
          out_reg <= out_next;
          sel_reg <= sel_next;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Address channels
  // ---------------------------------------------------------------------------
  assign S_AXI_AWREADY = s_aready[0];
  assign S_AXI_ARREADY = s_aready[1];

  assign M_AXI_AWVALID = m_avalid[0];
  assign M_AXI_AWID    = S_AXI_AWID;
  assign M_AXI_AWADDR  = S_AXI_AWADDR;
  assign M_AXI_AWLEN   = S_AXI_AWLEN;
  assign E_AXI_AWVALID = e_avalid[0];
  assign E_AXI_AWID    = S_AXI_AWID;
  assign E_AXI_AWADDR  = S_AXI_AWADDR;
  assign E_AXI_AWLEN   = S_AXI_AWLEN;

  assign M_AXI_ARVALID = m_avalid[1];
  assign M_AXI_ARID    = S_AXI_ARID;
  assign M_AXI_ARADDR  = S_AXI_ARADDR;
  assign M_AXI_ARLEN   = S_AXI_ARLEN;
  assign E_AXI_ARVALID = e_avalid[1];
  assign E_AXI_ARID    = S_AXI_ARID;
  assign E_AXI_ARADDR  = S_AXI_ARADDR;
  assign E_AXI_ARLEN   = S_AXI_ARLEN;

  // ---------------------------------------------------------------------------
  // Write data: W beats are only forwarded once their AW has been accepted,
  // which keeps W from reaching a slave before the select bit is valid.
  // ---------------------------------------------------------------------------
  logic [LGMAXBURST-1:0] w_bursts_reg, w_bursts_next;
  logic                  w_active;
  logic                  aw_hs;
  logic                  w_last_hs;

  assign aw_hs     = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_last_hs = S_AXI_WVALID && S_AXI_WREADY && S_AXI_WLAST;
  assign w_active  = !S_AXI_ARESET && (w_bursts_reg != '0);

  always_comb begin
    w_bursts_next = w_bursts_reg;
    if (aw_hs && !w_last_hs) begin
      w_bursts_next = w_bursts_reg + 1'b1;
    end else if (!aw_hs && w_last_hs) begin
      w_bursts_next = w_bursts_reg - 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_bursts_reg <= '0;
    end else begin
      w_bursts_reg <= w_bursts_next;
    end
  end

  assign S_AXI_WREADY = w_active && (dir_sel[0] ? E_AXI_WREADY : M_AXI_WREADY);
  assign M_AXI_WVALID = w_active && !dir_sel[0] && S_AXI_WVALID;
  assign E_AXI_WVALID = w_active && dir_sel[0] && S_AXI_WVALID;
  assign M_AXI_WDATA  = S_AXI_WDATA;
  assign M_AXI_WSTRB  = S_AXI_WSTRB;
  assign M_AXI_WLAST  = S_AXI_WLAST;
  assign E_AXI_WDATA  = S_AXI_WDATA;
  assign E_AXI_WSTRB  = S_AXI_WSTRB;
  assign E_AXI_WLAST  = S_AXI_WLAST;

  // ---------------------------------------------------------------------------
  // Responses: only the owning slave is visible; the other is stalled.
  // ---------------------------------------------------------------------------
  assign S_AXI_BVALID = !S_AXI_ARESET && (dir_sel[0] ? E_AXI_BVALID : M_AXI_BVALID);
  assign S_AXI_BID    = dir_sel[0] ? E_AXI_BID : M_AXI_BID;
  assign S_AXI_BRESP  = dir_sel[0] ? E_AXI_BRESP : M_AXI_BRESP;
  assign M_AXI_BREADY = !S_AXI_ARESET && !dir_sel[0] && S_AXI_BREADY;
  assign E_AXI_BREADY = !S_AXI_ARESET && dir_sel[0] && S_AXI_BREADY;

  assign S_AXI_RVALID = !S_AXI_ARESET && (dir_sel[1] ? E_AXI_RVALID : M_AXI_RVALID);
  assign S_AXI_RID    = dir_sel[1] ? E_AXI_RID : M_AXI_RID;
  assign S_AXI_RDATA  = dir_sel[1] ? E_AXI_RDATA : M_AXI_RDATA;
  assign S_AXI_RLAST  = dir_sel[1] ? E_AXI_RLAST : M_AXI_RLAST;
  assign S_AXI_RRESP  = dir_sel[1] ? E_AXI_RRESP : M_AXI_RRESP;
  assign M_AXI_RREADY = !S_AXI_ARESET && !dir_sel[1] && S_AXI_RREADY;
  assign E_AXI_RREADY = !S_AXI_ARESET && dir_sel[1] && S_AXI_RREADY;

endmodule

// File: tb/tb_axi_decerr_split.sv
// -----------------------------------------------------------------------------
// tb_axi_decerr_split
//
// Drives the upstream master and models both downstream slaves. Expected B and
// R responses are pushed to scoreboard queues when the address is driven and
// popped when the response appears on the S_AXI side. The mapped-slave model
// answers OKAY, the error-slave model answers 2'b11; slave-side IDs come from
// what the slaves actually observed on their AW/AR ports.
// -----------------------------------------------------------------------------
module tb_axi_decerr_split;

  localparam int IW = 2;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam logic [31:0] ERR_DATA = 32'hEEEE_0000;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
  } b_exp_t;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic          last;
    logic [1:0]    resp;
  } r_exp_t;

  logic S_AXI_ACLK, S_AXI_ARESET;
  logic S_AXI_AWVALID, S_AXI_AWREADY; logic [IW-1:0] S_AXI_AWID; logic [AW-1:0] S_AXI_AWADDR; logic [7:0] S_AXI_AWLEN;
  logic S_AXI_WVALID, S_AXI_WREADY; logic [DW-1:0] S_AXI_WDATA; logic [SW-1:0] S_AXI_WSTRB; logic S_AXI_WLAST;
  logic S_AXI_BVALID, S_AXI_BREADY; logic [IW-1:0] S_AXI_BID; logic [1:0] S_AXI_BRESP;
  logic S_AXI_ARVALID, S_AXI_ARREADY; logic [IW-1:0] S_AXI_ARID; logic [AW-1:0] S_AXI_ARADDR; logic [7:0] S_AXI_ARLEN;
  logic S_AXI_RVALID, S_AXI_RREADY; logic [IW-1:0] S_AXI_RID; logic [DW-1:0] S_AXI_RDATA; logic S_AXI_RLAST; logic [1:0] S_AXI_RRESP;

  logic M_AXI_AWVALID, M_AXI_AWREADY; logic [IW-1:0] M_AXI_AWID; logic [AW-1:0] M_AXI_AWADDR; logic [7:0] M_AXI_AWLEN;
  logic M_AXI_WVALID, M_AXI_WREADY; logic [DW-1:0] M_AXI_WDATA; logic [SW-1:0] M_AXI_WSTRB; logic M_AXI_WLAST;
  logic M_AXI_BVALID, M_AXI_BREADY; logic [IW-1:0] M_AXI_BID; logic [1:0] M_AXI_BRESP;
  logic M_AXI_ARVALID, M_AXI_ARREADY; logic [IW-1:0] M_AXI_ARID; logic [AW-1:0] M_AXI_ARADDR; logic [7:0] M_AXI_ARLEN;
  logic M_AXI_RVALID, M_AXI_RREADY; logic [IW-1:0] M_AXI_RID; logic [DW-1:0] M_AXI_RDATA; logic M_AXI_RLAST; logic [1:0] M_AXI_RRESP;

  logic E_AXI_AWVALID, E_AXI_AWREADY; logic [IW-1:0] E_AXI_AWID; logic [AW-1:0] E_AXI_AWADDR; logic [7:0] E_AXI_AWLEN;
  logic E_AXI_WVALID, E_AXI_WREADY; logic [DW-1:0] E_AXI_WDATA; logic [SW-1:0] E_AXI_WSTRB; logic E_AXI_WLAST;
  logic E_AXI_BVALID, E_AXI_BREADY; logic [IW-1:0] E_AXI_BID; logic [1:0] E_AXI_BRESP;
  logic E_AXI_ARVALID, E_AXI_ARREADY; logic [IW-1:0] E_AXI_ARID; logic [AW-1:0] E_AXI_ARADDR; logic [7:0] E_AXI_ARLEN;
  logic E_AXI_RVALID, E_AXI_RREADY; logic [IW-1:0] E_AXI_RID; logic [DW-1:0] E_AXI_RDATA; logic E_AXI_RLAST; logic [1:0] E_AXI_RRESP;

  int n_checks = 0;
  int n_fail   = 0;

  b_exp_t        exp_b[$];
  r_exp_t        exp_r[$];
  logic [IW-1:0] m_aw_q[$], e_aw_q[$], m_ar_q[$], e_ar_q[$];

  axi_decerr_split dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESET(S_AXI_ARESET),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
    .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_ARID(S_AXI_ARID), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY), .S_AXI_RID(S_AXI_RID), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RLAST(S_AXI_RLAST), .S_AXI_RRESP(S_AXI_RRESP),
    .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY), .M_AXI_ARID(M_AXI_ARID), .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARLEN(M_AXI_ARLEN),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY), .M_AXI_RID(M_AXI_RID), .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RLAST(M_AXI_RLAST), .M_AXI_RRESP(M_AXI_RRESP),
    .E_AXI_AWVALID(E_AXI_AWVALID), .E_AXI_AWREADY(E_AXI_AWREADY), .E_AXI_AWID(E_AXI_AWID), .E_AXI_AWADDR(E_AXI_AWADDR), .E_AXI_AWLEN(E_AXI_AWLEN),
    .E_AXI_WVALID(E_AXI_WVALID), .E_AXI_WREADY(E_AXI_WREADY), .E_AXI_WDATA(E_AXI_WDATA), .E_AXI_WSTRB(E_AXI_WSTRB), .E_AXI_WLAST(E_AXI_WLAST),
    .E_AXI_BVALID(E_AXI_BVALID), .E_AXI_BREADY(E_AXI_BREADY), .E_AXI_BID(E_AXI_BID), .E_AXI_BRESP(E_AXI_BRESP),
    .E_AXI_ARVALID(E_AXI_ARVALID), .E_AXI_ARREADY(E_AXI_ARREADY), .E_AXI_ARID(E_AXI_ARID), .E_AXI_ARADDR(E_AXI_ARADDR), .E_AXI_ARLEN(E_AXI_ARLEN),
    .E_AXI_RVALID(E_AXI_RVALID), .E_AXI_RREADY(E_AXI_RREADY), .E_AXI_RID(E_AXI_RID), .E_AXI_RDATA(E_AXI_RDATA), .E_AXI_RLAST(E_AXI_RLAST), .E_AXI_RRESP(E_AXI_RRESP)
  );

  initial S_AXI_ACLK = 1'b0;
  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  // Slave-side address monitor: inputs change just after posedge, so the
  // values seen at negedge are the ones the next posedge will accept.
  always @(negedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      m_aw_q.delete(); e_aw_q.delete(); m_ar_q.delete(); e_ar_q.delete();
    end else begin
      if (M_AXI_AWVALID && M_AXI_AWREADY) m_aw_q.push_back(M_AXI_AWID);
      if (E_AXI_AWVALID && E_AXI_AWREADY) e_aw_q.push_back(E_AXI_AWID);
      if (M_AXI_ARVALID && M_AXI_ARREADY) m_ar_q.push_back(M_AXI_ARID);
      if (E_AXI_ARVALID && E_AXI_ARREADY) e_ar_q.push_back(E_AXI_ARID);
    end
  end

  function automatic logic [14:0] hs_outs();
    return {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID,
            M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY,
            E_AXI_AWVALID, E_AXI_WVALID, E_AXI_BREADY, E_AXI_ARVALID, E_AXI_RREADY};
  endfunction

  task automatic tick();
    @(posedge S_AXI_ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    S_AXI_AWVALID = 0; S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0;
    S_AXI_WVALID = 0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 0;
    S_AXI_BREADY = 0; S_AXI_ARVALID = 0; S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0;
    S_AXI_RREADY = 0;
    M_AXI_AWREADY = 1; M_AXI_WREADY = 1; M_AXI_BVALID = 0; M_AXI_BID = '0; M_AXI_BRESP = '0;
    M_AXI_ARREADY = 1; M_AXI_RVALID = 0; M_AXI_RID = '0; M_AXI_RDATA = '0; M_AXI_RLAST = 0; M_AXI_RRESP = '0;
    E_AXI_AWREADY = 1; E_AXI_WREADY = 1; E_AXI_BVALID = 0; E_AXI_BID = '0; E_AXI_BRESP = '0;
    E_AXI_ARREADY = 1; E_AXI_RVALID = 0; E_AXI_RID = '0; E_AXI_RDATA = '0; E_AXI_RLAST = 0; E_AXI_RRESP = '0;
  endtask

  // Slave model returns one B; the scoreboard entry is checked on S_AXI_B*.
  task automatic respond_b(input logic to_e, input string tag);
    b_exp_t        ev;
    logic [IW-1:0] sid;
    sid = '0;
    if (to_e ? (e_aw_q.size() == 0) : (m_aw_q.size() == 0)) begin
      n_checks++; n_fail++;
      $display("FAIL %s_b_src: slave saw no AW, required one pending", tag);
    end else begin
      sid = to_e ? e_aw_q.pop_front() : m_aw_q.pop_front();
    end
    if (to_e) begin
      E_AXI_BVALID = 1; E_AXI_BID = sid; E_AXI_BRESP = 2'b11;
    end else begin
      M_AXI_BVALID = 1; M_AXI_BID = sid; M_AXI_BRESP = 2'b00;
    end
    S_AXI_BREADY = 1;
    #1;
    n_checks++;
    if (exp_b.size() == 0) begin
      n_fail++;
      $display("FAIL %s_b: response with empty scoreboard", tag);
    end else begin
      ev = exp_b.pop_front();
      $display("B %s id=%0d resp=%0d", tag, S_AXI_BID, S_AXI_BRESP);
      if ({S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP, M_AXI_BREADY, E_AXI_BREADY} !==
          {1'b1, ev.id, ev.resp, !to_e, to_e}) begin
        n_fail++;
        $display("FAIL %s_b: {bvalid,bid,bresp,m_bready,e_bready} got %b required %b", tag,
                 {S_AXI_BVALID, S_AXI_BID, S_AXI_BRESP, M_AXI_BREADY, E_AXI_BREADY},
                 {1'b1, ev.id, ev.resp, !to_e, to_e});
      end
    end
    tick();
    M_AXI_BVALID = 0; E_AXI_BVALID = 0; S_AXI_BREADY = 0;
  endtask

  // Full write burst: AW, LEN+1 beats, B. Routing expectation is decoded here.
  task automatic write_burst(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                             input logic [7:0] len, input string tag);
    logic          hit;
    logic [DW-1:0] d;
    hit = (addr[31:16] == 16'h0000);
    S_AXI_AWVALID = 1; S_AXI_AWID = id; S_AXI_AWADDR = addr; S_AXI_AWLEN = len;
    #1;
    n_checks++;
    if ({M_AXI_AWVALID, E_AXI_AWVALID, S_AXI_AWREADY} !== {hit, !hit, 1'b1}) begin
      n_fail++;
      $display("FAIL %s_aw: {m_awvalid,e_awvalid,s_awready} got %b required %b", tag,
               {M_AXI_AWVALID, E_AXI_AWVALID, S_AXI_AWREADY}, {hit, !hit, 1'b1});
    end
    exp_b.push_back('{id: id, resp: (hit ? 2'b00 : 2'b11)});
    tick();
    S_AXI_AWVALID = 0;
    for (int i = 0; i <= int'(len); i++) begin
      d = $urandom();
      S_AXI_WVALID = 1; S_AXI_WDATA = d; S_AXI_WSTRB = '1; S_AXI_WLAST = (i == int'(len));
      #1;
      n_checks++;
      if ({M_AXI_WVALID, E_AXI_WVALID, S_AXI_WREADY} !== {hit, !hit, 1'b1} ||
          (hit ? M_AXI_WDATA : E_AXI_WDATA) !== d) begin
        n_fail++;
        $display("FAIL %s_w%0d: {m_wvalid,e_wvalid,s_wready} got %b required %b data got %h required %h",
                 tag, i, {M_AXI_WVALID, E_AXI_WVALID, S_AXI_WREADY}, {hit, !hit, 1'b1},
                 (hit ? M_AXI_WDATA : E_AXI_WDATA), d);
      end
      tick();
    end
    S_AXI_WVALID = 0; S_AXI_WLAST = 0;
    respond_b(!hit, tag);
  endtask

  task automatic test_reset();
    S_AXI_ARESET = 1;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_BREADY = 1; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
    M_AXI_BVALID = 1; M_AXI_RVALID = 1; E_AXI_BVALID = 1; E_AXI_RVALID = 1;
    #1;
    n_checks++;
    if (hs_outs() !== 15'd0) begin
      n_fail++;
      $display("FAIL reset_hs: valid/ready outputs got %b required 0", hs_outs());
    end
    tick(); tick();
    idle_inputs();
    S_AXI_ARESET = 0;
    tick();
    $display("reset done");
  endtask

  task automatic test_hit_write();
    write_burst(2'd1, 32'h0000_1000, 8'd3, "hit_write");
  endtask

  task automatic test_miss_write();
    write_burst(2'd2, 32'h0002_0000, 8'd0, "miss_write");
  endtask

  task automatic test_read_switch();
    r_exp_t        ev;
    logic [IW-1:0] sid;
    S_AXI_ARVALID = 1; S_AXI_ARID = 2'd3; S_AXI_ARADDR = 32'h0000_0100; S_AXI_ARLEN = 8'd7;
    #1;
    n_checks++;
    if ({M_AXI_ARVALID, E_AXI_ARVALID, S_AXI_ARREADY} !== 3'b101) begin
      n_fail++;
      $display("FAIL rd_hit_ar: {m_arvalid,e_arvalid,s_arready} got %b required 101",
               {M_AXI_ARVALID, E_AXI_ARVALID, S_AXI_ARREADY});
    end
    for (int i = 0; i < 8; i++)
      exp_r.push_back('{id: 2'd3, data: 32'hD000_0000 | i, last: (i == 7), resp: 2'b00});
    tick();
    // Miss AR waits behind the outstanding hit burst.
    S_AXI_ARID = 2'd0; S_AXI_ARADDR = 32'h0003_0000; S_AXI_ARLEN = 8'd0;
    sid = '0;
    if (m_ar_q.size() != 0) sid = m_ar_q.pop_front();
    for (int i = 0; i < 8; i++) begin
      M_AXI_RVALID = 1; M_AXI_RID = sid; M_AXI_RDATA = 32'hD000_0000 | i;
      M_AXI_RLAST = (i == 7); M_AXI_RRESP = 2'b00; S_AXI_RREADY = 1;
      #1;
      n_checks++;
      if ({S_AXI_ARREADY, E_AXI_ARVALID, E_AXI_RREADY} !== 3'b000) begin
        n_fail++;
        $display("FAIL rd_block%0d: {s_arready,e_arvalid,e_rready} got %b required 000",
                 i, {S_AXI_ARREADY, E_AXI_ARVALID, E_AXI_RREADY});
      end
      n_checks++;
      ev = exp_r.pop_front();
      $display("R hit id=%0d data=%h last=%0d", S_AXI_RID, S_AXI_RDATA, S_AXI_RLAST);
      if ({S_AXI_RVALID, S_AXI_RID, S_AXI_RDATA, S_AXI_RLAST, S_AXI_RRESP} !== {1'b1, ev}) begin
        n_fail++;
        $display("FAIL rd_hit_r%0d: got %h required %h", i,
                 {S_AXI_RVALID, S_AXI_RID, S_AXI_RDATA, S_AXI_RLAST, S_AXI_RRESP}, {1'b1, ev});
      end
      tick();
    end
    M_AXI_RVALID = 0; M_AXI_RLAST = 0;
    #1;
    n_checks++;
    if ({M_AXI_ARVALID, E_AXI_ARVALID, S_AXI_ARREADY} !== 3'b011) begin
      n_fail++;
      $display("FAIL rd_miss_ar: {m_arvalid,e_arvalid,s_arready} got %b required 011",
               {M_AXI_ARVALID, E_AXI_ARVALID, S_AXI_ARREADY});
    end
    exp_r.push_back('{id: 2'd0, data: ERR_DATA, last: 1'b1, resp: 2'b11});
    tick();
    S_AXI_ARVALID = 0;
    sid = 2'd1;
    if (e_ar_q.size() != 0) sid = e_ar_q.pop_front();
    E_AXI_RVALID = 1; E_AXI_RID = sid; E_AXI_RDATA = ERR_DATA; E_AXI_RLAST = 1; E_AXI_RRESP = 2'b11;
    #1;
    n_checks++;
    ev = exp_r.pop_front();
    $display("R miss id=%0d resp=%0d", S_AXI_RID, S_AXI_RRESP);
    if ({S_AXI_RVALID, S_AXI_RID, S_AXI_RDATA, S_AXI_RLAST, S_AXI_RRESP, M_AXI_RREADY} !== {1'b1, ev, 1'b0}) begin
      n_fail++;
      $display("FAIL rd_miss_r: got %h required %h",
               {S_AXI_RVALID, S_AXI_RID, S_AXI_RDATA, S_AXI_RLAST, S_AXI_RRESP, M_AXI_RREADY}, {1'b1, ev, 1'b0});
    end
    tick();
    E_AXI_RVALID = 0; E_AXI_RLAST = 0; S_AXI_RREADY = 0;
  endtask

  task automatic test_w_before_aw();
    S_AXI_WVALID = 1; S_AXI_WDATA = 32'h1234_5678; S_AXI_WSTRB = '1; S_AXI_WLAST = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if ({S_AXI_WREADY, M_AXI_WVALID, E_AXI_WVALID} !== 3'b000) begin
        n_fail++;
        $display("FAIL w_early%0d: {s_wready,m_wvalid,e_wvalid} got %b required 000",
                 i, {S_AXI_WREADY, M_AXI_WVALID, E_AXI_WVALID});
      end
      tick();
    end
    S_AXI_AWVALID = 1; S_AXI_AWID = 2'd0; S_AXI_AWADDR = 32'h0000_2000; S_AXI_AWLEN = 8'd0;
    #1;
    n_checks++;
    if ({S_AXI_AWREADY, S_AXI_WREADY, M_AXI_WVALID} !== 3'b100) begin
      n_fail++;
      $display("FAIL w_aw_cycle: {s_awready,s_wready,m_wvalid} got %b required 100",
               {S_AXI_AWREADY, S_AXI_WREADY, M_AXI_WVALID});
    end
    exp_b.push_back('{id: 2'd0, resp: 2'b00});
    tick();
    S_AXI_AWVALID = 0;
    #1;
    n_checks++;
    if ({S_AXI_WREADY, M_AXI_WVALID, E_AXI_WVALID} !== 3'b110) begin
      n_fail++;
      $display("FAIL w_flow: {s_wready,m_wvalid,e_wvalid} got %b required 110",
               {S_AXI_WREADY, M_AXI_WVALID, E_AXI_WVALID});
    end
    tick();
    S_AXI_WVALID = 0; S_AXI_WLAST = 0;
    respond_b(1'b0, "w_before_aw");
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 8; i++) begin
      S_AXI_AWVALID = 1; S_AXI_AWID = 2'(i); S_AXI_AWADDR = 32'h0000_0100 * i; S_AXI_AWLEN = 8'd0;
      #1;
      n_checks++;
      if ({S_AXI_AWREADY, M_AXI_AWVALID} !== ((i < 7) ? 2'b11 : 2'b00)) begin
        n_fail++;
        $display("FAIL sat_aw%0d: {s_awready,m_awvalid} got %b required %b",
                 i, {S_AXI_AWREADY, M_AXI_AWVALID}, ((i < 7) ? 2'b11 : 2'b00));
      end
      if (i < 7) begin
        exp_b.push_back('{id: 2'(i), resp: 2'b00});
        tick();
        S_AXI_AWVALID = 0;
        S_AXI_WVALID = 1; S_AXI_WLAST = 1; S_AXI_WDATA = 32'(i);
        tick();
        S_AXI_WVALID = 0; S_AXI_WLAST = 0;
      end
    end
    tick();
    #1;
    n_checks++;
    if (S_AXI_AWREADY !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_hold: s_awready got %b required 0", S_AXI_AWREADY);
    end
    respond_b(1'b0, "sat_first");
    #1;
    n_checks++;
    if ({S_AXI_AWREADY, M_AXI_AWVALID} !== 2'b11) begin
      n_fail++;
      $display("FAIL sat_release: {s_awready,m_awvalid} got %b required 11",
               {S_AXI_AWREADY, M_AXI_AWVALID});
    end
    exp_b.push_back('{id: 2'(7), resp: 2'b00});
    tick();
    S_AXI_AWVALID = 0;
    S_AXI_WVALID = 1; S_AXI_WLAST = 1;
    tick();
    S_AXI_WVALID = 0; S_AXI_WLAST = 0;
    for (int i = 0; i < 7; i++) respond_b(1'b0, "sat_drain");
  endtask

  task automatic test_reset_mid_burst();
    S_AXI_AWVALID = 1; S_AXI_AWID = 2'd1; S_AXI_AWADDR = 32'h0000_3000; S_AXI_AWLEN = 8'd3;
    tick();
    S_AXI_AWVALID = 0;
    for (int i = 0; i < 2; i++) begin
      S_AXI_WVALID = 1; S_AXI_WDATA = 32'(i); S_AXI_WLAST = 0;
      tick();
    end
    S_AXI_ARESET = 1;
    S_AXI_AWVALID = 1; S_AXI_BREADY = 1; S_AXI_ARVALID = 1; S_AXI_RREADY = 1;
    M_AXI_BVALID = 1; E_AXI_BVALID = 1; M_AXI_RVALID = 1; E_AXI_RVALID = 1;
    #1;
    n_checks++;
    if (hs_outs() !== 15'd0) begin
      n_fail++;
      $display("FAIL midrst_hs: valid/ready outputs got %b required 0", hs_outs());
    end
    tick(); tick();
    exp_b.delete();
    idle_inputs();
    S_AXI_ARESET = 0;
    tick();
    write_burst(2'd2, 32'h0005_0000, 8'd0, "post_reset_miss");
  endtask

  initial begin
    S_AXI_ARESET = 1;
    idle_inputs();
    tick();
    test_reset();
    test_hit_write();
    test_miss_write();
    test_read_switch();
    test_w_before_aw();
    test_saturation();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
